// File: rtl/subseq_gen_if.sv
// rtl/subseq_gen_if.sv - handshake and serial-output bundle for the subsequence pattern generator
`timescale 1ns/1ps
interface subseq_gen_if #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int REP_W = 4
);
    logic             start;
    logic [PAT_W-1:0] pat;
    logic [LEN_W-1:0] pat_len;
    logic [REP_W-1:0] rep;
    logic             abort;
    logic             x;
    logic             ready;
    logic             busy;
    logic             done;
    logic [2:0]       state;

    modport master (
        output start, pat, pat_len, rep, abort,
        input  x, ready, busy, done, state
    );

    modport slave (
        input  start, pat, pat_len, rep, abort,
        output x, ready, busy, done, state
    );
endinterface

// File: rtl/subseq_gen.sv
// rtl/subseq_gen.sv - MSB-first pattern serializer with repeat count; SUBSEQ_GEN_GAP_EN adds idle gaps between repeats
`timescale 1ns/1ps
module subseq_gen #(
    parameter int PAT_W   = 8,
    parameter int LEN_W   = 4,
    parameter int REP_W   = 4,
    parameter int GAP_LEN = 2
) (
    input  logic         clk,
    input  logic         rst,
    subseq_gen_if.slave  bus
);
    if (GAP_LEN < 1 || (2 ** LEN_W) <= PAT_W) begin : g_bad_params
        $error("subseq_gen: illegal parameter combination");
    end

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SHIFT = 3'd1,
        GAP   = 3'd2,
        DONE  = 3'd3
    } state_t;

    state_t           st, st_d;
    logic [PAT_W-1:0] pat_q, pat_d, sh;
    logic [LEN_W-1:0] len_q, len_d, idx_q, idx_d, len_eff;
    logic [REP_W-1:0] rep_q, rep_d, rep_eff;
    logic             x_q, x_d;
`ifdef SUBSEQ_GEN_GAP_EN
    localparam int GAP_W = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;
    logic [GAP_W-1:0] gap_q, gap_d;
`endif

    always_comb begin
        len_eff = (bus.pat_len == '0 || bus.pat_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.pat_len;
        rep_eff = (bus.rep == '0) ? REP_W'(1) : bus.rep;
    end

    always_ff @(posedge clk) begin
        if (rst) st <= IDLE;
        else     st <= st_d;
    end

    // All next values come from here; x is the bit selected by the next index.
    always_comb begin
        st_d  = st;
        pat_d = pat_q;
        len_d = len_q;
        idx_d = idx_q;
        rep_d = rep_q;
        x_d   = 1'b0;
        sh    = '0;
`ifdef SUBSEQ_GEN_GAP_EN
        gap_d = gap_q;
`endif
        case (st)
            IDLE: begin
                if (bus.start) begin
                    pat_d = bus.pat;
                    len_d = len_eff;
                    idx_d = len_eff - LEN_W'(1);
                    rep_d = rep_eff;
                    sh    = bus.pat >> idx_d;
                    x_d   = sh[0];
                    st_d  = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.abort) begin
                    st_d = IDLE;
                end else if (idx_q != '0) begin
                    idx_d = idx_q - LEN_W'(1);
                    sh    = pat_q >> idx_d;
                    x_d   = sh[0];
                end else if (rep_q > REP_W'(1)) begin
                    rep_d = rep_q - REP_W'(1);
                    idx_d = len_q - LEN_W'(1);
`ifdef SUBSEQ_GEN_GAP_EN
                    gap_d = '0;
                    st_d  = GAP;
`else
                    sh    = pat_q >> idx_d;
                    x_d   = sh[0];
`endif
                end else begin
                    st_d = DONE;
                end
            end
            GAP: begin
`ifdef SUBSEQ_GEN_GAP_EN
                if (bus.abort) begin
                    st_d = IDLE;
                end else if (gap_q == GAP_W'(GAP_LEN - 1)) begin
                    sh   = pat_q >> idx_q;
                    x_d  = sh[0];
                    st_d = SHIFT;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
`else
                st_d = IDLE;
`endif
            end
            DONE:    st_d = IDLE;
            default: st_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q <= '0;
            len_q <= '0;
            idx_q <= '0;
            rep_q <= '0;
            x_q   <= 1'b0;
`ifdef SUBSEQ_GEN_GAP_EN
            gap_q <= '0;
`endif
        end else begin
            pat_q <= pat_d;
            len_q <= len_d;
            idx_q <= idx_d;
            rep_q <= rep_d;
            x_q   <= x_d;
`ifdef SUBSEQ_GEN_GAP_EN
            gap_q <= gap_d;
`endif
        end
    end

    always_comb begin
        bus.x     = x_q;
        bus.ready = (st == IDLE);
        bus.busy  = (st == SHIFT) || (st == GAP);
        bus.done  = (st == DONE);
        bus.state = st;
    end
endmodule

// File: doc/subseq_gen.md
Name: subseq_gen

Overview:
- Serial bit-pattern transmitter and the driving end of the subsequence-checker interface.
- Accepts a parallel pattern, length and repeat count, then emits the pattern MSB-first on one serial bit `x`, one bit per clock.
- Used as the stimulus source for the sequence detector and as a reusable serializer elsewhere in the design.

Parameters:
- PAT_W, 8, maximum pattern width in bits.
- LEN_W, 4, width of pat_len; must satisfy 2^LEN_W > PAT_W.
- REP_W, 4, width of the repeat count.
- GAP_LEN, 2, number of idle zero bits inserted between repetitions (only used with SUBSEQ_GEN_GAP_EN).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request to begin a transmission; sampled only when ready=1.
- pat  input  PAT_W  pattern; the bit at index pat_len-1 is sent first.
- pat_len  input  LEN_W  number of bits to send per repetition; values 0 or >PAT_W are treated as PAT_W.
- rep  input  REP_W  number of repetitions; 0 is treated as 1.
- abort  input  1  cancels an active transmission.
- x  output  1  serial data out (registered).
- ready  output  1  high in IDLE only.
- busy  output  1  high in SHIFT or GAP.
- done  output  1  one-cycle pulse after normal completion.
- state  output  3  current FSM state: IDLE=0, SHIFT=1, GAP=2, DONE=3.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, x=0, ready=1, busy=0, done=0, internal counters cleared. rst overrides start and abort on the same edge.
- IDLE, on an edge with start=1:
  - latch pat, effective length L and effective repeat count R;
  - drive x<=pat[L-1]; set bit index to L-1 and repetitions-remaining to R;
  - go to SHIFT.
- In IDLE with start=0, x holds 0.
- SHIFT: each edge sends the next lower bit.
  - After bit index 0 of a repetition, if repetitions remain, the next edge starts a new repetition: x<=pat[L-1] back-to-back, or enter GAP when the gap feature is compiled in.
  - After bit 0 of the final repetition, the next edge sets x<=0 and moves to DONE.
- Latency: start accepted at edge E0. Bit k (k=0 first) of the stream is valid from edge E0+k until edge E0+k+1. Total stream length with no gap is L*R cycles.
- DONE: lasts exactly one cycle with done=1, x=0, then IDLE (ready=1). Start is ignored in DONE.
- start while busy or in DONE is ignored. Latched inputs are not affected by later changes on pat, pat_len or rep.
- abort=1 in SHIFT or GAP: next edge goes to IDLE with x=0 and no done pulse. abort in IDLE or DONE has no effect.
- Simultaneous abort and end-of-stream: abort wins (no done).
- L=1: one bit per repetition, legal. R at its maximum (2^REP_W-1) must not wrap early.
- Counters are sized for exact wrap-free range; no arithmetic overflow is permitted.

Optional Feature:
- Macro SUBSEQ_GEN_GAP_EN.
- Defined: between consecutive repetitions the FSM enters GAP for exactly GAP_LEN cycles with x=0, busy=1, then resumes SHIFT with x=pat[L-1]. There is no gap after the final repetition. Total stream length is L*R + GAP_LEN*(R-1) cycles.
- Undefined: the GAP state is unreachable, GAP_LEN is unused, and repetitions are back-to-back.

Test Plan:
- Reset: hold rst=1 for 2 edges with start=1 -> x=0, ready=1, busy=0, done=0, state=0; no transmission starts.
- pat=8'b00010001, pat_len=5, rep=3, no gap, start for 1 cycle -> x = 1,0,0,0,1,1,0,0,0,1,1,0,0,0,1 on 15 consecutive cycles, then done=1 for 1 cycle, then ready=1.
- Same stimulus with SUBSEQ_GEN_GAP_EN and GAP_LEN=2 -> x = 10001 00 10001 00 10001 (19 cycles), state=2 during the gap bits, then a single done pulse.
- pat_len=0, pat=8'hA5, rep=0 -> exactly 8 bits 1,0,1,0,0,1,0,1 sent once, then done.
- Assert abort on the 3rd bit of pat=5'b10001 with L=5, R=2 -> next cycle x=0, state=0, ready=1, and done never pulses. start asserted mid-stream on an earlier run is ignored.
- Assert rst mid-SHIFT -> next cycle all outputs at reset values. A new start then reproduces the full stream from bit 0.
